uart_rx_fsm: RTL and testbench

Control FSM for the UART receiver. It drives the enables of the edge/bit counter and sampling datapath, and consumes their edge_cnt, bit_cnt, sampled_bit and P_DATA outputs. Per frame it checks start-bit glitches, parity and the stop bit, then presents the received byte with a one-cycle valid strobe.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_chk.sv | 71 +++++++
 rtl/uart_rx_fsm.sv | 132 +++++++++++++
 tb/tb_uart_rx_fsm.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encoding, width defaults and parity constants for the UART receiver
package uart_rx_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRESCALE_W_DEF = 5;
    localparam int BIT_CNT_W_DEF  = 4;

    localparam logic PAR_TYP_EVEN = 1'b0;
    localparam logic PAR_TYP_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_chk.sv
// rtl/uart_rx_chk.sv - parity/stop error flags; UART_RX_ERR_CNT_EN adds a saturating per-frame error counter
module uart_rx_chk
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  par_chk_i,
    input  logic                  stop_chk_i,
    input  logic                  sampled_bit_i,
    input  logic                  par_typ_i,
    input  logic [DATA_WIDTH-1:0] shadow_i,
`ifdef UART_RX_ERR_CNT_EN
    output logic [7:0]            err_cnt_o,
`endif
    output logic                  par_err_o,
    output logic                  stop_err_o
);

    logic exp_par;
    logic par_err_q, par_err_d;
    logic stop_err_q, stop_err_d;

    assign exp_par = (^shadow_i) ^ (par_typ_i == PAR_TYP_ODD);

    always_comb begin
        par_err_d  = par_err_q;
        stop_err_d = stop_err_q;
        if (clr_i) begin
            par_err_d  = 1'b0;
            stop_err_d = 1'b0;
        end else begin
            if (par_chk_i)  par_err_d  = (sampled_bit_i != exp_par);
            if (stop_chk_i) stop_err_d = ~sampled_bit_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
        end
    end

    assign par_err_o  = par_err_q;
    assign stop_err_o = stop_err_q;

`ifdef UART_RX_ERR_CNT_EN
    // Count only the first flag raised in a frame so a double fault counts once.
    logic       err_new;
    logic [7:0] err_cnt_q;

    assign err_new = (par_err_d | stop_err_d) & ~(par_err_q | stop_err_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (err_new && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receiver control FSM; define UART_RX_ERR_CNT_EN to add the Err_Count output
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF,
    parameter int BIT_CNT_W  = BIT_CNT_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [BIT_CNT_W-1:0]  bit_cnt,
    input  logic                  sampled_bit,
    input  logic [DATA_WIDTH-1:0] P_DATA,
`ifdef UART_RX_ERR_CNT_EN
    output logic [7:0]            Err_Count,
`endif
    output logic                  data_samp_en,
    output logic                  Counter_enable,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  data_valid,
    output logic                  Parity_Error,
    output logic                  Stop_Error
);

    localparam logic [PRESCALE_W-1:0] PS_ONE   = PRESCALE_W'(1);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT = BIT_CNT_W'(DATA_WIDTH);

    rx_state_e             state_q, state_d;
    logic                  eob;
    logic                  run;
    logic                  start_det, cap, par_chk, stop_chk, frame_ok;
    logic                  par_en_q, par_typ_q;
    logic [DATA_WIDTH-1:0] shadow_q, rx_data_q;
    logic                  valid_q;

    assign eob = (edge_cnt == (Prescale - PS_ONE));

    always_comb begin
        state_d   = state_q;
        run       = 1'b1;
        start_det = 1'b0;
        cap       = 1'b0;
        par_chk   = 1'b0;
        stop_chk  = 1'b0;
        frame_ok  = 1'b0;
        case (state_q)
            IDLE: begin
                run = 1'b0;
                if (!RX_IN) begin
                    state_d   = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (eob) state_d = sampled_bit ? IDLE : DATA;
            end
            DATA: begin
                if (eob && (bit_cnt == LAST_BIT)) begin
                    cap     = 1'b1;
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (eob) begin
                    par_chk = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (eob) begin
                    stop_chk = 1'b1;
                    frame_ok = sampled_bit & ~Parity_Error;
                    state_d  = IDLE;
                end
            end
            default: begin
                run     = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            shadow_q  <= '0;
            rx_data_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= frame_ok;
            // Frame options are frozen at start detection so mid-frame changes cannot corrupt the checks.
            if (start_det) begin
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
            if (cap)      shadow_q  <= P_DATA;
            if (frame_ok) rx_data_q <= shadow_q;
        end
    end

    uart_rx_chk #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_chk (
        .clk          (CLK),
        .rst_n        (RST),
        .clr_i        (start_det),
        .par_chk_i    (par_chk),
        .stop_chk_i   (stop_chk),
        .sampled_bit_i(sampled_bit),
        .par_typ_i    (par_typ_q),
        .shadow_i     (shadow_q),
`ifdef UART_RX_ERR_CNT_EN
        .err_cnt_o    (Err_Count),
`endif
        .par_err_o    (Parity_Error),
        .stop_err_o   (Stop_Error)
    );

    assign Counter_enable = run;
    assign data_samp_en   = run;
    assign RX_DATA        = rx_data_q;
    assign data_valid     = valid_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - scoreboard bench for uart_rx_fsm with a behavioural counter/deserializer
module tb_uart_rx_fsm;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [4:0] Prescale = 5'd8;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sampled_bit;
    logic [7:0] P_DATA;
    logic       data_samp_en, Counter_enable, data_valid, Parity_Error, Stop_Error;
    logic [7:0] RX_DATA;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] Err_Count;
`endif

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_b;
    logic       dv_prev = 1'b0;

    uart_rx_fsm dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_IN         (RX_IN),
        .PAR_EN        (PAR_EN),
        .PAR_TYP       (PAR_TYP),
        .Prescale      (Prescale),
        .edge_cnt      (edge_cnt),
        .bit_cnt       (bit_cnt),
        .sampled_bit   (sampled_bit),
        .P_DATA        (P_DATA),
`ifdef UART_RX_ERR_CNT_EN
        .Err_Count     (Err_Count),
`endif
        .data_samp_en  (data_samp_en),
        .Counter_enable(Counter_enable),
        .RX_DATA       (RX_DATA),
        .data_valid    (data_valid),
        .Parity_Error  (Parity_Error),
        .Stop_Error    (Stop_Error)
    );

    always #5 CLK = ~CLK;

    // The line is held constant for a whole bit, so the voted sample equals the line.
    assign sampled_bit = RX_IN;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= 4'd0;
            P_DATA   <= 8'd0;
        end else if (!Counter_enable) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= 4'd0;
        end else begin
            if (edge_cnt == Prescale - 5'd1) begin
                edge_cnt <= 5'd0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + 5'd1;
            end
            if (edge_cnt == Prescale - 5'd2 && bit_cnt >= 4'd1 && bit_cnt <= 4'd8)
                P_DATA <= {sampled_bit, P_DATA[7:1]};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge CLK) begin
        if (RST && data_valid) begin
            check("valid_single_cycle", {31'd0, dv_prev}, 32'd0);
            check("valid_expected", {31'd0, (sb.size() > 0)}, 32'd1);
            if (sb.size() > 0) begin
                exp_b = sb.pop_front();
                check("rx_data_on_valid", {24'd0, RX_DATA}, {24'd0, exp_b});
            end
        end
        dv_prev <= data_valid;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic pen, input logic ptyp,
                              input logic pbit, input logic stopb, input logic [4:0] ps,
                              input logic good);
        Prescale = ps;
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        if (good) sb.push_back(b);
        RX_IN = 1'b0;
        cyc(int'(ps) + 1);
        for (int i = 0; i < 8; i++) begin
            RX_IN = b[i];
            cyc(int'(ps));
        end
        if (pen) begin
            RX_IN = pbit;
            cyc(int'(ps));
        end
        RX_IN = stopb;
        cyc(int'(ps));
        RX_IN = 1'b1;
    endtask

    task automatic check_flags(input string name, input logic pe, input logic se);
        check({name, "_parity_err"}, {31'd0, Parity_Error}, {31'd0, pe});
        check({name, "_stop_err"}, {31'd0, Stop_Error}, {31'd0, se});
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rx_data"}, {24'd0, RX_DATA}, 32'd0);
        check({name, "_valid"}, {31'd0, data_valid}, 32'd0);
        check({name, "_cnt_en"}, {31'd0, Counter_enable}, 32'd0);
        check({name, "_samp_en"}, {31'd0, data_samp_en}, 32'd0);
        check_flags(name, 1'b0, 1'b0);
`ifdef UART_RX_ERR_CNT_EN
        check({name, "_err_count"}, {24'd0, Err_Count}, 32'd0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        check_reset_outputs("reset");
        RST = 1'b1;
        cyc(2);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1);
        check_flags("a5", 1'b0, 1'b0);
        cyc(2);

        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 5'd16, 1'b1);
        check_flags("3c_even", 1'b0, 1'b0);
        cyc(2);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 5'd16, 1'b0);
        check_flags("3c_bad_par", 1'b1, 1'b0);
        check("3c_bad_par_hold", {24'd0, RX_DATA}, 32'h3C);
        cyc(2);

        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 5'd16, 1'b0);
        check_flags("01_bad_stop", 1'b0, 1'b1);
        check("01_bad_stop_hold", {24'd0, RX_DATA}, 32'h3C);
        cyc(2);

        Prescale = 5'd8;
        RX_IN = 1'b0;
        cyc(3);
        check("glitch_cnt_en_active", {31'd0, Counter_enable}, 32'd1);
        RX_IN = 1'b1;
        cyc(8);
        check("glitch_cnt_en_idle", {31'd0, Counter_enable}, 32'd0);
        check_flags("glitch", 1'b0, 1'b0);
        cyc(2);

        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1);
        cyc(2);
        check("b2b_rx_data", {24'd0, RX_DATA}, 32'hAA);
        check("b2b_sb_drained", sb.size(), 32'd0);

        PAR_EN = 1'b0;
        Prescale = 5'd8;
        RX_IN = 1'b0;
        cyc(9);
        RX_IN = 1'b1;
        cyc(16);
        check("ff_in_data_cnt_en", {31'd0, Counter_enable}, 32'd1);
        #2 RST = 1'b0;
        #1 check_reset_outputs("midframe_rst");
        cyc(2);
        RST = 1'b1;
        cyc(2);
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1);
        cyc(2);
        check("after_rst_rx_data", {24'd0, RX_DATA}, 32'h12);
        check_flags("after_rst", 1'b0, 1'b0);

`ifdef UART_RX_ERR_CNT_EN
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
        cyc(2);
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0);
        cyc(2);
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0);
        check_flags("double_fault", 1'b1, 1'b1);
        cyc(2);
        check("err_count_three", {24'd0, Err_Count}, 32'd3);
`endif

        cyc(3);
        check("sb_empty_end", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
